// File: rtl/univ_reg_ne_pkg.sv
// Shared constants for the falling-edge universal register: operation codes
// and the default register width.
package univ_reg_ne_pkg;

  localparam int DEFAULT_WIDTH = 4;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_INC  = 3'b110;
  localparam logic [2:0] MODE_DEC  = 3'b111;

endpackage

// File: rtl/univ_reg_cell.sv
// One bit of the universal register: 8:1 next-state mux feeding a falling-edge
// flip-flop whose async clear/preset is picked by RST_BIT.
module univ_reg_cell
  import univ_reg_ne_pkg::*;
#(
  parameter logic RST_BIT = 1'b0
) (
  input  logic       C,
  input  logic       RE,
  input  logic       EN,
  input  logic [2:0] MODE,
  input  logic       ld,
  input  logic       shl,
  input  logic       shr,
  input  logic       rol,
  input  logic       ror,
  input  logic       inc,
  input  logic       dec,
  output logic       q,
  output logic       qn
);

  logic nxt;

  always_comb begin
    nxt = q;
    if (EN) begin
      case (MODE)
        MODE_HOLD: nxt = q;
        MODE_LOAD: nxt = ld;
        MODE_SHL:  nxt = shl;
        MODE_SHR:  nxt = shr;
        MODE_ROL:  nxt = rol;
        MODE_ROR:  nxt = ror;
        MODE_INC:  nxt = inc;
        MODE_DEC:  nxt = dec;
        default:   nxt = q;
      endcase
    end
  end

  always_ff @(negedge C or negedge RE) begin
    if (!RE) q <= RST_BIT;
    else     q <= nxt;
  end

  // Derived from the stored bit so it stays the exact complement even when MODE is X.
  assign qn = ~q;

endmodule

// File: rtl/univ_reg_ne.sv
// WIDTH-bit universal register (hold/load/shift/rotate/count), falling-edge
// clocked, with serial and terminal-count cascade pins.
module univ_reg_ne
  import univ_reg_ne_pkg::*;
#(
  parameter int               WIDTH   = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             C,
  input  logic             RE,
  input  logic             EN,
  input  logic [2:0]       MODE,
  input  logic [WIDTH-1:0] D,
  input  logic             SIL,
  input  logic             SIR,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qnot,
  output logic             SOL,
  output logic             SOR,
  output logic             TC
);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qn;
  logic [WIDTH-1:0] shl_v, shr_v, rol_v, ror_v, inc_v, dec_v;
  logic             inc_co, dec_bo;

  assign shl_v = {q[WIDTH-2:0], SIL};
  assign shr_v = {SIR, q[WIDTH-1:1]};
  assign rol_v = {q[WIDTH-2:0], q[WIDTH-1]};
  assign ror_v = {q[0], q[WIDTH-1:1]};

  // Ripple carry/borrow chains; the final carry/borrow doubles as the wrap flag.
  always_comb begin
    logic c, b;
    c = 1'b1;
    b = 1'b1;
    inc_v = '0;
    dec_v = '0;
    for (int i = 0; i < WIDTH; i++) begin
      inc_v[i] = q[i] ^ c;
      dec_v[i] = q[i] ^ b;
      c = c & q[i];
      b = b & ~q[i];
    end
    inc_co = c;
    dec_bo = b;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    univ_reg_cell #(
      .RST_BIT (RST_VAL[i])
    ) u_cell (
      .C    (C),
      .RE   (RE),
      .EN   (EN),
      .MODE (MODE),
      .ld   (D[i]),
      .shl  (shl_v[i]),
      .shr  (shr_v[i]),
      .rol  (rol_v[i]),
      .ror  (ror_v[i]),
      .inc  (inc_v[i]),
      .dec  (dec_v[i]),
      .q    (q[i]),
      .qn   (qn[i])
    );
  end

  assign Q    = q;
  assign Qnot = qn;
  assign SOL  = q[WIDTH-1];
  assign SOR  = q[0];
  assign TC   = EN & (((MODE == MODE_INC) & inc_co) | ((MODE == MODE_DEC) & dec_bo));

endmodule
